// File: rtl/adc_responder_if.sv
// Sample-source handshake between adc_responder (master) and the upstream sample generator (slave).
interface adc_responder_if;
    logic        sample_req;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic [11:0] sample_data;

    modport master (
        output sample_req,
        output sample_ch,
        input  sample_valid,
        input  sample_data
    );

    modport slave (
        input  sample_req,
        input  sample_ch,
        output sample_valid,
        output sample_data
    );
endinterface

// File: rtl/adc_responder.sv
// Emulates a 4-wire serial ADC (CONVST/SCK/SDI/SDO, 12-bit data, 6-bit config, one-frame config pipeline).
// Optional protocol checker enabled by defining ADC_RESP_CHECK_EN.
module adc_responder #(
    parameter int unsigned CONV_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ADC_CONVST,
    input  logic            ADC_SCK,
    input  logic            ADC_SDI,
    output logic            ADC_SDO,
    adc_responder_if.master smp,
    output logic [5:0]      cur_cfg,
    output logic            frame_done,
    output logic            sleeping,
    output logic            underrun,
    output logic            proto_err
);
    localparam int unsigned CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, SLEEP} state_t;
    state_t state, state_next;

    // [0],[1] synchronize, [2] is the edge-detect history
    logic [2:0] convst_sync, sck_sync;
    logic [1:0] sdi_sync;
    logic convst_rise, sck_rise, sck_fall, sdi;

    logic [CW-1:0] conv_cnt;
    logic [3:0]    fall_cnt;
    logic [2:0]    rise_cnt;
    logic [4:0]    cfg_sr;
    logic [10:0]   word;
    logic [11:0]   cap_data, raw, formatted;
    logic          captured, have_sample, conv_uni;
    logic          start_conv, conv_end, do_fall, do_rise, frame_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_sync <= '0;
            sck_sync    <= '0;
            sdi_sync    <= '0;
        end else begin
            convst_sync <= {convst_sync[1:0], ADC_CONVST};
            sck_sync    <= {sck_sync[1:0], ADC_SCK};
            sdi_sync    <= {sdi_sync[0], ADC_SDI};
        end
    end

    assign convst_rise = convst_sync[1] & ~convst_sync[2];
    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign sdi         = sdi_sync[1];

    // A sample arriving on the final conversion cycle still counts.
    assign have_sample = captured | smp.sample_valid;
    assign raw         = captured ? cap_data : smp.sample_data;
    assign formatted   = !have_sample ? '0 :
                         conv_uni ? raw : {~raw[11], raw[10:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_conv = 1'b0;
        conv_end   = 1'b0;
        do_fall    = 1'b0;
        do_rise    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                end else if (conv_cnt == '0) begin
                    conv_end   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_next = CONV;
                end else begin
                    do_rise = sck_rise && (rise_cnt < 3'd6);
                    if (sck_fall) begin
                        do_fall = 1'b1;
                        if (fall_cnt == 4'd11) begin
                            frame_end  = 1'b1;
                            state_next = cur_cfg[0] ? SLEEP : IDLE;
                        end
                    end
                end
            end
            SLEEP: begin
                if (convst_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sleeping = (state == SLEEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp.sample_req <= 1'b0;
            smp.sample_ch  <= '0;
            frame_done     <= 1'b0;
            ADC_SDO        <= 1'b0;
            cur_cfg        <= 6'b100010;
            underrun       <= 1'b0;
            conv_cnt       <= '0;
            fall_cnt       <= '0;
            rise_cnt       <= '0;
            cfg_sr         <= '0;
            word           <= '0;
            cap_data       <= '0;
            captured       <= 1'b0;
            conv_uni       <= 1'b0;
        end else begin
            smp.sample_req <= start_conv;
            frame_done     <= frame_end;
            if (start_conv) begin
                smp.sample_ch <= {cur_cfg[3], cur_cfg[2], cur_cfg[4]};
                conv_uni      <= cur_cfg[1];
                conv_cnt      <= CW'(CONV_CYCLES - 1);
                captured      <= 1'b0;
                fall_cnt      <= '0;
                rise_cnt      <= '0;
                ADC_SDO       <= 1'b0;
            end else if (state == CONV) begin
                if (conv_cnt != '0) conv_cnt <= conv_cnt - 1'b1;
                if (smp.sample_valid && !captured) begin
                    captured <= 1'b1;
                    cap_data <= smp.sample_data;
                end
                if (conv_end) begin
                    word    <= formatted[10:0];
                    ADC_SDO <= formatted[11];
                    if (!have_sample) underrun <= 1'b1;
                end
            end
            if (do_fall) begin
                fall_cnt <= fall_cnt + 1'b1;
                word     <= {word[9:0], 1'b0};
                ADC_SDO  <= frame_end ? 1'b0 : word[10];
            end
            // Config commits only on the 6th rise; a shorter frame leaves cur_cfg alone.
            if (do_rise) begin
                rise_cnt <= rise_cnt + 1'b1;
                cfg_sr   <= {cfg_sr[3:0], sdi};
                if (rise_cnt == 3'd5) cur_cfg <= {cfg_sr, sdi};
            end
        end
    end

`ifdef ADC_RESP_CHECK_EN
    logic [1:0] convst_hi;
    logic [3:0] frame_falls;
    logic       convst_fall;

    assign convst_fall = ~convst_sync[1] & convst_sync[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_hi   <= '0;
            frame_falls <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (convst_sync[1]) convst_hi <= (convst_hi == 2'd3) ? convst_hi : convst_hi + 1'b1;
            else                convst_hi <= '0;
            if (start_conv || state == SLEEP)
                frame_falls <= '0;
            else if (sck_fall && frame_falls != 4'hF)
                frame_falls <= frame_falls + 1'b1;
            if ((state == CONV && (sck_rise || sck_fall)) ||
                (convst_fall && convst_hi < 2'd2) ||
                (sck_fall && state != SLEEP && frame_falls >= 4'd12) ||
                (convst_rise && state == SHIFT))
                proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_adc_responder.sv
// Directed and randomized frames against a frame-level reference model of adc_responder.
module tb_adc_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        adc_convst, adc_sck, adc_sdi;
    logic        adc_sdo;
    logic [5:0]  cur_cfg;
    logic        frame_done, sleeping, underrun, proto_err;

    adc_responder_if smp_if ();

    adc_responder #(.CONV_CYCLES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ADC_CONVST (adc_convst),
        .ADC_SCK    (adc_sck),
        .ADC_SDI    (adc_sdi),
        .ADC_SDO    (adc_sdo),
        .smp        (smp_if),
        .cur_cfg    (cur_cfg),
        .frame_done (frame_done),
        .sleeping   (sleeping),
        .underrun   (underrun),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: config in force and sticky underrun.
    logic [5:0] cfg_m;
    bit         underrun_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] chan_of(input logic [5:0] c);
        // ch = {S1, S0, O/S}
        return 3'(c[3] * 4 + c[2] * 2 + c[4]);
    endfunction

    task automatic start_frame(input bit expect_req);
        adc_convst = 1'b1;
        tick(2);
        chk("req_early", smp_if.sample_req, 0);
        tick(1);
        chk("req_pulse", smp_if.sample_req, expect_req);
        if (expect_req) chk("sample_ch", smp_if.sample_ch, chan_of(cfg_m));
        tick(1);
        chk("req_end", smp_if.sample_req, 0);
        adc_convst = 1'b0;
    endtask

    task automatic run_frame(input logic [11:0] s, input bit have, input logic [5:0] cfg_tx,
                             input int nfalls);
        logic [11:0] exp_word;
        logic [11:0] rx;
        int          first;
        int          cnt;
        exp_word = !have ? 12'h000 : (cfg_m[1] ? s : (s ^ 12'h800));
        start_frame(1'b1);
        if (have) begin
            tick(2);
            smp_if.sample_valid = 1'b1;
            smp_if.sample_data  = s;
            tick(1);
            smp_if.sample_valid = 1'b0;
            smp_if.sample_data  = 12'($urandom);
            tick(2);
            smp_if.sample_valid = 1'b1;
            smp_if.sample_data  = ~s;
            tick(1);
            smp_if.sample_valid = 1'b0;
        end else begin
            tick(6);
        end
        tick(56);
        chk("sdo_conv", adc_sdo, 0);
        tick(1);
        chk("sdo_msb", adc_sdo, exp_word[11]);
        rx = '0;
        for (int i = 0; i < nfalls; i++) begin
            adc_sdi = (i < 6) ? cfg_tx[5 - i] : 1'($urandom);
            tick(4);
            rx[11 - i] = adc_sdo;
            adc_sck = 1'b1;
            tick(4);
            adc_sck = 1'b0;
        end
        if (!have) underrun_m = 1'b1;
        if (nfalls >= 6) cfg_m = cfg_tx;
        if (nfalls == 12) begin
            first = -1;
            cnt   = 0;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                if (frame_done) begin
                    cnt++;
                    if (first < 0) first = k;
                end
            end
            chk("done_count", cnt, 1);
            chk("done_lat", first, 2);
            chk("rx_word", rx, exp_word);
            chk("sdo_idle", adc_sdo, 0);
            chk("cur_cfg", cur_cfg, cfg_m);
            chk("underrun", underrun, underrun_m);
            chk("sleeping", sleeping, cfg_m[0]);
        end else begin
            chk("rx_partial", rx >> (12 - nfalls), exp_word >> (12 - nfalls));
            chk("cfg_partial", cur_cfg, cfg_m);
        end
    endtask

    initial begin
        logic [5:0] rcfg;
        reset_n    = 1'b0;
        adc_convst = 1'b0;
        adc_sck    = 1'b0;
        adc_sdi    = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_data  = '0;
        cfg_m      = 6'b100010;
        underrun_m = 1'b0;

        tick(3);
        chk("rst_sdo", adc_sdo, 0);
        chk("rst_req", smp_if.sample_req, 0);
        chk("rst_ch", smp_if.sample_ch, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cfg", cur_cfg, 6'b100010);
        chk("rst_sleep", sleeping, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_proto", proto_err, 0);
        reset_n = 1'b1;
        tick(2);

        // Directed pipeline frames: config takes effect one conversion later.
        run_frame(12'hA5C, 1'b1, 6'b110010, 12);
        run_frame(12'h800, 1'b1, 6'b100100, 12);
        run_frame(12'h800, 1'b1, 6'b110010, 12);

        for (int n = 0; n < 3; n++) begin
            rcfg = 6'($urandom) & 6'b111110;
            run_frame(12'($urandom), 1'b1, rcfg, 12);
        end

        // Underrun, then a good frame keeps the sticky flag.
        run_frame(12'($urandom), 1'b0, 6'($urandom) & 6'b111110, 12);
        run_frame(12'($urandom), 1'b1, 6'b100000, 12);

        // Sleep entry, wake without conversion, then a normal frame.
        run_frame(12'($urandom), 1'b1, 6'b100011, 12);
        start_frame(1'b0);
        tick(2);
        chk("wake_sleep", sleeping, 0);
        run_frame(12'($urandom), 1'b1, 6'b110010, 12);
        chk("proto_before_abort", proto_err, 0);

        // Abort after 5 SCK falls.
        run_frame(12'($urandom), 1'b1, 6'b001101, 5);
        run_frame(12'($urandom), 1'b1, 6'b100110, 12);
`ifdef ADC_RESP_CHECK_EN
        chk("proto_abort", proto_err, 1);
`else
        chk("proto_abort", proto_err, 0);
`endif

        // Reset during SHIFT clears outputs asynchronously.
        run_frame(12'hFFF, 1'b1, 6'b010101, 3);
        chk("sdo_pre_rst", adc_sdo, 1);
        reset_n = 1'b0;
        #1;
        chk("async_sdo", adc_sdo, 0);
        chk("async_cfg", cur_cfg, 6'b100010);
        chk("async_underrun", underrun, 0);
        tick(3);
        reset_n    = 1'b1;
        cfg_m      = 6'b100010;
        underrun_m = 1'b0;
        tick(2);
        run_frame(12'($urandom), 1'b1, 6'b110110, 12);
        run_frame(12'($urandom), 1'b1, 6'b100010, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
